// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings common to TX and RX, baud divisors, clog2 helper.
package uart_pkg;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] START   = 3'd1;
  localparam logic [2:0] DATA    = 3'd2;
  localparam logic [2:0] STOP    = 3'd3;
  localparam logic [2:0] CLEANUP = 3'd4;

  // Clocks per bit from a 50 MHz system clock.
  localparam int CPB_115200 = 434;
  localparam int CPB_57600  = 868;
  localparam int CPB_19200  = 2604;
  localparam int CPB_9600   = 5208;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous input; reset value is a parameter.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling. Define UART_RX_MAJORITY_EN for a
// 2-of-3 vote around each sample point (all decisions move one cycle later).
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_PER_BIT = 434,
  parameter int DATAWIDTH_BUS = 8,
  parameter int STATE_SIZE    = 3
) (
  input  logic                     UART_RX_CLOCK_50,
  input  logic                     UART_RX_RESET_InHigh,
  input  logic                     UART_RX_rx_In,
  output logic [DATAWIDTH_BUS-1:0] UART_RX_data_Out,
  output logic                     UART_RX_newData_Out,
  output logic                     UART_RX_busy_Out,
  output logic                     UART_RX_frameError_Out
);

  localparam int HALF = CLOCK_PER_BIT / 2;
  localparam int CW   = clog2(CLOCK_PER_BIT);
  localparam int BW   = clog2(DATAWIDTH_BUS);
`ifdef UART_RX_MAJORITY_EN
  localparam int LAG  = 1;
`else
  localparam int LAG  = 0;
`endif

  localparam logic [STATE_SIZE-1:0] S_IDLE    = STATE_SIZE'(IDLE);
  localparam logic [STATE_SIZE-1:0] S_START   = STATE_SIZE'(START);
  localparam logic [STATE_SIZE-1:0] S_DATA    = STATE_SIZE'(DATA);
  localparam logic [STATE_SIZE-1:0] S_STOP    = STATE_SIZE'(STOP);
  localparam logic [STATE_SIZE-1:0] S_CLEANUP = STATE_SIZE'(CLEANUP);

  localparam logic [CW-1:0] START_LAST = CW'(HALF - 1 + LAG);
  localparam logic [CW-1:0] BIT_LAST   = CW'(CLOCK_PER_BIT - 1);
  localparam logic [BW-1:0] IDX_LAST   = BW'(DATAWIDTH_BUS - 1);

  logic                     w_sync;
  logic                     w_smp;
  logic [STATE_SIZE-1:0]    r_state;
  logic [CW-1:0]            r_cnt;
  logic [BW-1:0]            r_idx;
  logic [DATAWIDTH_BUS-1:0] r_shift;
  logic [DATAWIDTH_BUS-1:0] r_data;
  logic                     r_new;
  logic                     r_ferr;
  logic                     r_break;

  uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
    .i_clk   (UART_RX_CLOCK_50),
    .i_rst   (UART_RX_RESET_InHigh),
    .i_async (UART_RX_rx_In),
    .o_sync  (w_sync)
  );

`ifdef UART_RX_MAJORITY_EN
  // r_hist[0] is rx_sync one edge ago, r_hist[1] two edges ago.
  logic [1:0] r_hist;

  always_ff @(posedge UART_RX_CLOCK_50) begin
    if (UART_RX_RESET_InHigh) r_hist <= 2'b11;
    else                      r_hist <= {r_hist[0], w_sync};
  end

  assign w_smp = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_sync) | (r_hist[0] & w_sync);
`else
  assign w_smp = w_sync;
`endif

  always_ff @(posedge UART_RX_CLOCK_50) begin
    if (UART_RX_RESET_InHigh) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_new   <= 1'b0;
      r_ferr  <= 1'b0;
      r_break <= 1'b0;
    end else begin
      r_new  <= 1'b0;
      r_ferr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          // After a framing error the line must go high again before re-arming.
          if (w_sync)        r_break <= 1'b0;
          else if (!r_break) r_state <= S_START;
        end
        S_START: begin
          if (r_cnt == START_LAST) begin
            r_cnt <= '0;
            r_idx <= '0;
            r_state <= w_smp ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt <= '0;
            r_shift[r_idx] <= w_smp;
            if (r_idx == IDX_LAST) r_state <= S_STOP;
            else                   r_idx   <= r_idx + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt   <= '0;
            r_state <= S_CLEANUP;
            if (w_smp) begin
              r_data <= r_shift;
              r_new  <= 1'b1;
            end else begin
              r_ferr  <= 1'b1;
              r_break <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_CLEANUP: r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  assign UART_RX_data_Out       = r_data;
  assign UART_RX_newData_Out    = r_new;
  assign UART_RX_frameError_Out = r_ferr;
  assign UART_RX_busy_Out       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CLOCK_PER_BIT=16 against a frame-level timing model.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int LAG = 1;
`else
  localparam int LAG = 0;
`endif
  // From the cycle the start bit is first driven to the cycle the strobe is visible:
  // 2 synchronizer flops + 1 IDLE detect edge, then HALF + 9 bit periods.
  localparam int LAT = 3 + HALF + 9 * CPB + LAG;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       nd, busy, fe;

  uart_rx #(.CLOCK_PER_BIT(CPB), .DATAWIDTH_BUS(8), .STATE_SIZE(3)) dut (
    .UART_RX_CLOCK_50       (clk),
    .UART_RX_RESET_InHigh   (rst),
    .UART_RX_rx_In          (rx),
    .UART_RX_data_Out       (data),
    .UART_RX_newData_Out    (nd),
    .UART_RX_busy_Out       (busy),
    .UART_RX_frameError_Out (fe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int kind; logic [7:0] d; } ev_t;  // kind 1=newData, 2=frameError
  ev_t got_q[$];
  ev_t exp_q[$];
  int  bz_rise[$];
  int  bz_fall[$];
  int  n_viol = 0;
  int  n_cmp  = 0;
  int  n_bad  = 0;
  logic [7:0] last_good = 8'h00;
  logic pnd = 1'b0, pfe = 1'b0, pbz = 1'b0;

  always @(negedge clk) begin
    ev_t e;
    if (nd && fe)  n_viol++;
    if (nd && pnd) n_viol++;
    if (fe && pfe) n_viol++;
    if (nd || fe) begin
      e.cyc = cyc; e.kind = nd ? 1 : 2; e.d = data;
      got_q.push_back(e);
    end
    if (busy && !pbz) bz_rise.push_back(cyc);
    if (!busy && pbz) bz_fall.push_back(cyc);
    pnd = nd; pfe = fe; pbz = busy;
  end

  // Reference model: a frame whose start bit is driven from cycle e0 yields one
  // event LAT cycles later; a bad stop bit leaves the output byte unchanged.
  task automatic expect_frame(input int e0, input logic [7:0] b, input logic stop);
    ev_t e;
    e.cyc = e0 + LAT; e.kind = stop ? 1 : 2; e.d = stop ? b : last_good;
    if (stop) last_good = b;
    exp_q.push_back(e);
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop, input int gc, output int e0);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    e0 = 0;
    for (int c = 0; c < 10 * CPB; c++) begin
      @(posedge clk); #1;
      if (c == 0) e0 = cyc;
      rx = bits[c / CPB] ^ (c == gc);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic stop, input int gc);
    int e0;
    drive_frame(b, stop, gc, e0);
    expect_frame(e0, b, stop);
  endtask

  task automatic line(input logic v, input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; rx = v; end
  endtask

  task automatic clear_q();
    got_q.delete(); exp_q.delete(); bz_rise.delete(); bz_fall.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", data); end
    n_cmp++; if (nd !== 1'b0) begin n_bad++; $display("FAIL reset_newData: got %b want 0", nd); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (fe !== 1'b0) begin n_bad++; $display("FAIL reset_frameError: got %b want 0", fe); end
    rst = 1'b0; last_good = 8'h00;
    line(1'b1, 2 * CPB);
  endtask

  task automatic test_single();
    int e0;
    clear_q();
    drive_frame(8'hA5, 1'b1, -1, e0);
    expect_frame(e0, 8'hA5, 1'b1);
    line(1'b1, 3 * CPB);
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL single_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_cmp++;
      if (got_q[i].cyc != exp_q[i].cyc || got_q[i].kind != exp_q[i].kind || got_q[i].d !== exp_q[i].d) begin
        n_bad++; $display("FAIL single_ev%0d: got cyc=%0d kind=%0d d=%h want cyc=%0d kind=%0d d=%h", i, got_q[i].cyc, got_q[i].kind, got_q[i].d, exp_q[i].cyc, exp_q[i].kind, exp_q[i].d);
      end
    end
    n_cmp++; if (bz_rise.size() != 1 || bz_rise[0] != e0 + 3) begin n_bad++; $display("FAIL single_busy_rise: got n=%0d first=%0d want %0d", bz_rise.size(), (bz_rise.size() > 0) ? bz_rise[0] : -1, e0 + 3); end
    n_cmp++; if (bz_fall.size() != 1 || bz_fall[0] != e0 + LAT + 1) begin n_bad++; $display("FAIL single_busy_fall: got n=%0d first=%0d want %0d", bz_fall.size(), (bz_fall.size() > 0) ? bz_fall[0] : -1, e0 + LAT + 1); end
  endtask

  task automatic test_back_to_back();
    clear_q();
    send(8'h00, 1'b1, -1);
    send(8'hFF, 1'b1, -1);
    send(8'h80, 1'b1, -1);
    line(1'b1, 3 * CPB);
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_cmp++;
      if (got_q[i].cyc != exp_q[i].cyc || got_q[i].kind != exp_q[i].kind || got_q[i].d !== exp_q[i].d) begin
        n_bad++; $display("FAIL b2b_ev%0d: got cyc=%0d kind=%0d d=%h want cyc=%0d kind=%0d d=%h", i, got_q[i].cyc, got_q[i].kind, got_q[i].d, exp_q[i].cyc, exp_q[i].kind, exp_q[i].d);
      end
    end
  endtask

  task automatic test_glitch();
    int e0;
    clear_q();
    @(posedge clk); #1; e0 = cyc; rx = 1'b0;
    line(1'b0, 3);
    line(1'b1, 3 * CPB);
    n_cmp++; if (got_q.size() != 0) begin n_bad++; $display("FAIL glitch_events: got %0d want 0", got_q.size()); end
    n_cmp++; if (bz_rise.size() != 1 || bz_rise[0] != e0 + 3) begin n_bad++; $display("FAIL glitch_busy_rise: got n=%0d want at %0d", bz_rise.size(), e0 + 3); end
    n_cmp++;
    if (bz_fall.size() != 1 || bz_fall[0] != e0 + 3 + HALF + LAG || bz_fall[0] - (e0 + 3) > HALF + 3) begin
      n_bad++; $display("FAIL glitch_busy_fall: got n=%0d first=%0d want %0d", bz_fall.size(), (bz_fall.size() > 0) ? bz_fall[0] : -1, e0 + 3 + HALF + LAG);
    end
  endtask

  task automatic test_frame_error();
    clear_q();
    send(8'h11, 1'b1, -1);
    send(8'h3C, 1'b0, -1);
    line(1'b0, 3 * CPB);
    line(1'b1, CPB);
    send(8'h77, 1'b1, -1);
    line(1'b1, 3 * CPB);
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL ferr_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_cmp++;
      if (got_q[i].cyc != exp_q[i].cyc || got_q[i].kind != exp_q[i].kind || got_q[i].d !== exp_q[i].d) begin
        n_bad++; $display("FAIL ferr_ev%0d: got cyc=%0d kind=%0d d=%h want cyc=%0d kind=%0d d=%h", i, got_q[i].cyc, got_q[i].kind, got_q[i].d, exp_q[i].cyc, exp_q[i].kind, exp_q[i].d);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] bits;
    clear_q();
    bits = {1'b1, 8'h5A, 1'b0};
    for (int c = 0; c <= 5 * CPB + 4; c++) begin
      @(posedge clk); #1;
      rx = bits[c / CPB];
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_cmp++; if (data !== 8'h00) begin n_bad++; $display("FAIL rstmid_data: got %h want 00", data); end
    rst = 1'b0; rx = 1'b1; last_good = 8'h00;
    line(1'b1, 12 * CPB);
    send(8'hC3, 1'b1, -1);
    line(1'b1, 3 * CPB);
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rstmid_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_cmp++;
      if (got_q[i].cyc != exp_q[i].cyc || got_q[i].kind != exp_q[i].kind || got_q[i].d !== exp_q[i].d) begin
        n_bad++; $display("FAIL rstmid_ev%0d: got cyc=%0d kind=%0d d=%h want cyc=%0d kind=%0d d=%h", i, got_q[i].cyc, got_q[i].kind, got_q[i].d, exp_q[i].cyc, exp_q[i].kind, exp_q[i].d);
      end
    end
  endtask

  // With the vote enabled the glitch lands on the bit-3 sample point; without it
  // the glitch sits between sample points and must be ignored either way.
  task automatic test_glitch_bit();
    clear_q();
`ifdef UART_RX_MAJORITY_EN
    send(8'h0F, 1'b1, HALF + 4 * CPB);
`else
    send(8'h0F, 1'b1, HALF + 4 * CPB + 4);
`endif
    line(1'b1, 3 * CPB);
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL gbit_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_cmp++;
      if (got_q[i].cyc != exp_q[i].cyc || got_q[i].kind != exp_q[i].kind || got_q[i].d !== exp_q[i].d) begin
        n_bad++; $display("FAIL gbit_ev%0d: got cyc=%0d kind=%0d d=%h want cyc=%0d kind=%0d d=%h", i, got_q[i].cyc, got_q[i].kind, got_q[i].d, exp_q[i].cyc, exp_q[i].kind, exp_q[i].d);
      end
    end
  endtask

  task automatic test_random();
    clear_q();
    for (int n = 0; n < 24; n++) begin
      send(8'($urandom_range(0, 255)), 1'b1, -1);
      line(1'b1, $urandom_range(0, 3));
    end
    line(1'b1, 3 * CPB);
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_cmp++;
      if (got_q[i].cyc != exp_q[i].cyc || got_q[i].kind != exp_q[i].kind || got_q[i].d !== exp_q[i].d) begin
        n_bad++; $display("FAIL rand_ev%0d: got cyc=%0d kind=%0d d=%h want cyc=%0d kind=%0d d=%h", i, got_q[i].cyc, got_q[i].kind, got_q[i].d, exp_q[i].cyc, exp_q[i].kind, exp_q[i].d);
      end
    end
    n_cmp++; if (data !== last_good) begin n_bad++; $display("FAIL rand_final_data: got %h want %h", data, last_good); end
  endtask

  task automatic test_protocol();
    n_cmp++; if (n_viol != 0) begin n_bad++; $display("FAIL strobe_rules: got %0d violations want 0", n_viol); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_mid();
    test_glitch_bit();
    test_random();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
